// File: rtl/mc_sequencer.sv
// mc_sequencer: state register and write-enable gating for the multi-cycle MIPS controller.
// Holds memory states until mem_ready, traps on illegal opcodes and memory timeouts,
// and parks the core in HALT at an instruction boundary when halt_req is high.
// Optional build macro MC_PERF_CNT_EN adds the cycle_cnt / instr_cnt performance counters.
//
//  state | meaning
//  ------+-------------------------------------------------
//  0     | fetch (memory state, waits for mem_ready)
//  1     | decode, opcode legality check
//  2     | memory address compute
//  3     | load read (memory state)
//  4     | load write-back (retires)
//  5     | store write (memory state, retires)
//  6     | R-type execute
//  7     | R-type write-back (retires)
//  8     | branch (retires)
//  9     | jump (retires)
//  E     | HALT, core parked until halt_req drops
//  F     | TRAP, illegal opcode or bus timeout, exits only via reset
module mc_sequencer #(
  parameter int MAX_WAIT = 255,
  parameter int WAIT_W   = 8
`ifdef MC_PERF_CNT_EN
  , parameter int CNT_W  = 32
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op_code,
  input  logic [3:0]       mcu_ns,
  input  logic             mcu_pcwr,
  input  logic             mcu_pcwrcond,
  input  logic             mcu_irwr,
  input  logic             mcu_regwr,
  input  logic             mcu_memrd,
  input  logic             mcu_memwr,
  input  logic             mem_ready,
  input  logic             halt_req,
  output logic [3:0]       state,
  output logic             pc_wr,
  output logic             pc_wr_cond,
  output logic             ir_wr,
  output logic             reg_wr,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             instr_done,
  output logic             halted,
  output logic             illegal,
  output logic             bus_err
`ifdef MC_PERF_CNT_EN
  , output logic [CNT_W-1:0] cycle_cnt
  , output logic [CNT_W-1:0] instr_cnt
`endif
);

  typedef enum logic [3:0] {
    ST_FETCH  = 4'h0,
    ST_DECODE = 4'h1,
    ST_MEMADR = 4'h2,
    ST_MEMRD  = 4'h3,
    ST_MEMWB  = 4'h4,
    ST_MEMWR  = 4'h5,
    ST_EXEC   = 4'h6,
    ST_ALUWB  = 4'h7,
    ST_BRANCH = 4'h8,
    ST_JUMP   = 4'h9,
    ST_HALT   = 4'hE,
    ST_TRAP   = 4'hF
  } state_t;

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              illegal_q, illegal_d;
  logic              bus_err_q, bus_err_d;
  logic              instr_done_q, instr_done_d;

  logic   mem_state;
  logic   op_legal;
  logic   timeout;
  logic   retire;
  state_t ns_follow;
  state_t nxt;

  // Next-state, wait counter, sticky traps and retire detection
  always_comb begin
    mem_state = (state_q == ST_FETCH) || (state_q == ST_MEMRD) || (state_q == ST_MEMWR);
    op_legal  = (op_code == 6'h00) || (op_code == 6'h23) || (op_code == 6'h2B) ||
                (op_code == 6'h04) || (op_code == 6'h02);
    timeout   = mem_state && !mem_ready && (wait_cnt_q == WAIT_LAST);
    // The control unit only ever names states 0-9; anything else is treated as a fault.
    ns_follow = (mcu_ns <= 4'd9) ? state_t'(mcu_ns) : ST_TRAP;

    nxt        = state_q;
    wait_cnt_d = '0;
    illegal_d  = illegal_q;
    bus_err_d  = bus_err_q;

    case (state_q)
      ST_TRAP: nxt = ST_TRAP;
      ST_HALT: nxt = halt_req ? ST_HALT : ST_FETCH;
      ST_DECODE: begin
        if (op_legal) begin
          nxt = ns_follow;
        end else begin
          nxt       = ST_TRAP;
          illegal_d = 1'b1;
        end
      end
      ST_FETCH, ST_MEMRD, ST_MEMWR: begin
        if (mem_ready) begin
          nxt = ns_follow;
        end else if (timeout) begin
          nxt       = ST_TRAP;
          bus_err_d = 1'b1;
        end else begin
          nxt        = state_q;
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      default: nxt = ns_follow;
    endcase

    retire = ((state_q == ST_MEMWB) || (state_q == ST_MEMWR) || (state_q == ST_ALUWB) ||
              (state_q == ST_BRANCH) || (state_q == ST_JUMP)) && (nxt == ST_FETCH);
    instr_done_d = retire;

    // Halt only takes effect at an instruction boundary, i.e. when heading to fetch.
    // A fetch still waiting for memory also counts, which covers the first fetch after reset.
    state_d = ((nxt == ST_FETCH) && halt_req) ? ST_HALT : nxt;
  end

  // Gated outputs: combinational from the registered state, dropped at once while in reset
  always_comb begin
    state      = state_q;
    halted     = (state_q == ST_HALT);
    illegal    = illegal_q;
    bus_err    = bus_err_q;
    instr_done = instr_done_q;
    pc_wr      = 1'b0;
    pc_wr_cond = 1'b0;
    ir_wr      = 1'b0;
    reg_wr     = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    if (rst_n && (state_q != ST_HALT) && (state_q != ST_TRAP)) begin
      mem_rd = mcu_memrd;
      mem_wr = mcu_memwr;
      if (mem_state) begin
        pc_wr      = mcu_pcwr & mem_ready;
        pc_wr_cond = mcu_pcwrcond & mem_ready;
        ir_wr      = mcu_irwr & mem_ready;
        reg_wr     = mcu_regwr & mem_ready;
      end else begin
        pc_wr      = mcu_pcwr;
        pc_wr_cond = mcu_pcwrcond;
        ir_wr      = mcu_irwr;
        reg_wr     = mcu_regwr;
      end
    end
  end

`ifdef MC_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;

  // Performance counters: cycles freeze in TRAP, instructions count with the retire pulse
  always_comb begin
    cycle_cnt_d = (state_q == ST_TRAP) ? cycle_cnt_q : cycle_cnt_q + CNT_W'(1);
    instr_cnt_d = instr_done_d ? instr_cnt_q + CNT_W'(1) : instr_cnt_q;
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign instr_cnt = instr_cnt_q;
`endif

  // Sequencer state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_FETCH;
      wait_cnt_q   <= '0;
      illegal_q    <= 1'b0;
      bus_err_q    <= 1'b0;
      instr_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      illegal_q    <= illegal_d;
      bus_err_q    <= bus_err_d;
      instr_done_q <= instr_done_d;
    end
  end

endmodule
